// File: rtl/ab_pair_serializer.sv
// Wide-word to {a,b} pair serializer: captures up to NUM_PAIRS packed pairs per
// transfer and emits one registered pair per valid/ready beat.
module ab_pair_serializer #(
  parameter int FIELD_W     = 8,
  parameter int NUM_PAIRS   = 4,
  parameter int MSB_FIRST   = 0,
  parameter int SWAP_FIELDS = 0,
  localparam int PAIR_W     = 2 * FIELD_W,
  localparam int DATA_W     = NUM_PAIRS * PAIR_W,
  localparam int CNT_W      = $clog2(NUM_PAIRS + 1),
  localparam int IDX_W      = $clog2(NUM_PAIRS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CNT_W-1:0]   in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_a,
  output logic [FIELD_W-1:0] out_b,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic [7:0]         err_cnt,
  output logic               dbg_state
);

  // Handshake: a transfer moves on any rising edge where valid & ready are both
  // high; valid never waits on ready, and a presented beat holds until taken.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [FIELD_W-1:0] out_a_q, out_a_d;
  logic [FIELD_W-1:0] out_b_q, out_b_d;
  logic               out_last_q, out_last_d;
  logic [7:0]         err_q, err_d;

  logic               accept;
  logic               beat;
  logic               over_range;
  logic [CNT_W-1:0]   n_eff;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   step_idx;

  function automatic logic [PAIR_W-1:0] pick(input logic [DATA_W-1:0] w,
                                             input logic [IDX_W-1:0]  i);
    return w[int'(i)*PAIR_W +: PAIR_W];
  endfunction

  // Returns {out_a, out_b} for a packed {a, b} pair.
  function automatic logic [PAIR_W-1:0] order(input logic [PAIR_W-1:0] p);
    if (SWAP_FIELDS != 0) return {p[FIELD_W-1:0], p[PAIR_W-1:FIELD_W]};
    else                  return p;
  endfunction

  assign out_valid = (state_q == SEND);
  assign in_ready  = (state_q == IDLE) | (out_valid & out_ready & out_last_q);
  assign accept    = in_valid & in_ready;
  assign beat      = out_valid & out_ready;

  assign over_range = (in_count > CNT_W'(NUM_PAIRS));
  assign n_eff      = over_range ? CNT_W'(NUM_PAIRS) : in_count;
  assign first_idx  = (MSB_FIRST != 0) ? IDX_W'(n_eff - CNT_W'(1)) : '0;
  assign step_idx   = (MSB_FIRST != 0) ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    out_last_d = out_last_q;
    err_d      = err_q;

    if (accept) begin
      hold_d = in_data;
      if (over_range && (err_q != 8'hFF)) err_d = err_q + 8'd1;
      if (n_eff == '0) begin
        state_d    = IDLE;
        out_last_d = 1'b0;
      end else begin
        // First beat decodes straight from in_data; hold_q is not loaded yet.
        state_d              = SEND;
        idx_d                = first_idx;
        last_idx_d           = (MSB_FIRST != 0) ? '0 : IDX_W'(n_eff - CNT_W'(1));
        {out_a_d, out_b_d}   = order(pick(in_data, first_idx));
        out_last_d           = (n_eff == CNT_W'(1));
      end
    end else if (beat) begin
      if (out_last_q) begin
        state_d    = IDLE;
        out_last_d = 1'b0;
      end else begin
        idx_d              = step_idx;
        {out_a_d, out_b_d} = order(pick(hold_q, step_idx));
        out_last_d         = (step_idx == last_idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_last_q <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_last_q <= out_last_d;
      err_q      <= err_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign err_cnt   = err_q;
  assign dbg_state = (state_q == SEND);

endmodule

// File: tb/tb_ab_pair_serializer.sv
// Bench for ab_pair_serializer: instance 0 uses defaults, instance 1 uses
// MSB_FIRST=1 / SWAP_FIELDS=1; beats are checked against a queue-based model.
module tb_ab_pair_serializer;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int CW = 3;
  localparam int IW = 2;
  localparam int BW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic [CW-1:0] in_count  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [7:0]    out_a     [2];
  logic [7:0]    out_b     [2];
  logic [IW-1:0] out_idx   [2];
  logic          out_last  [2];
  logic [7:0]    err_cnt   [2];
  logic          dbg_state [2];

  logic [BW-1:0] exp_q[$];
  int            err_exp [2];
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  always #5 clk = ~clk;

  ab_pair_serializer #(.FIELD_W(8), .NUM_PAIRS(NP), .MSB_FIRST(0), .SWAP_FIELDS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_count(in_count[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_a(out_a[0]), .out_b(out_b[0]),
    .out_idx(out_idx[0]), .out_last(out_last[0]), .err_cnt(err_cnt[0]), .dbg_state(dbg_state[0])
  );

  ab_pair_serializer #(.FIELD_W(8), .NUM_PAIRS(NP), .MSB_FIRST(1), .SWAP_FIELDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_count(in_count[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_a(out_a[1]), .out_b(out_b[1]),
    .out_idx(out_idx[1]), .out_last(out_last[1]), .err_cnt(err_cnt[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] obs_beat(input int u);
    return {out_a[u], out_b[u], out_idx[u], out_last[u]};
  endfunction

  // Reference: n = min(count, NP) beats; instance 1 walks pairs downward and swaps fields.
  task automatic model_push(input int u, input logic [63:0] d, input int cnt);
    int n;
    int j;
    logic [15:0] p;
    logic [7:0] a;
    logic [7:0] b;
    n = (cnt > NP) ? NP : cnt;
    if (cnt > NP && err_exp[u] < 255) err_exp[u]++;
    for (int k = 0; k < n; k++) begin
      j = (u == 1) ? (n - 1 - k) : k;
      p = 16'((d >> (16 * j)) & 64'hFFFF);
      a = p[15:8];
      b = p[7:0];
      if (u == 1) exp_q.push_back({b, a, 2'(j), (k == n - 1)});
      else        exp_q.push_back({a, b, 2'(j), (k == n - 1)});
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on beat 1
  task automatic xfer(input int u, input logic [63:0] d, input int cnt, input int mode);
    int   guard;
    int   taken;
    int   stall_n;
    logic rdy;
    model_push(u, d, cnt);
    @(negedge clk);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_count[u] = 3'(cnt);
    #1 check("accept_ready", 64'(in_ready[u]), 64'd1);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_data[u]  = {$urandom(), $urandom()};
    guard = 0; taken = 0; stall_n = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(taken == 1 && stall_n < 5);
      endcase
      if (!rdy) stall_n++;
      out_ready[u] = rdy;
      #1;
      check("valid_pending", 64'(out_valid[u]), 64'd1);
      if (out_valid[u]) begin
        check("beat", 64'(obs_beat(u)), 64'(exp_q[0]));
        if (rdy) begin
          void'(exp_q.pop_front());
          taken++;
        end
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    out_ready[u] = 1'b1;
    #1;
    check("no_extra_beat", 64'(out_valid[u]), 64'd0);
    check("idle_ready", 64'(in_ready[u]), 64'd1);
    check("err_cnt", 64'(err_cnt[u]), 64'(err_exp[u]));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; in_count[u] = '0; out_ready[u] = 1'b0;
      err_exp[u] = 0;
    end

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_in_ready_during", 64'(in_ready[0]), 64'd1);
    rst_n = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_out_valid", 64'(out_valid[u]), 64'd0);
      check("rst_out_beat", 64'(obs_beat(u)), 64'd0);
      check("rst_in_ready", 64'(in_ready[u]), 64'd1);
      check("rst_err_cnt", 64'(err_cnt[u]), 64'd0);
    end

    // Ascending full transfer and descending swapped transfer
    xfer(0, 64'h0102_0304_0506_0708, 4, 0);
    xfer(1, 64'h0102_0304_0506_0708, 3, 0);

    // Backpressure on beat 1
    xfer(0, 64'hA1B2_C3D4_E5F6_0718, 4, 2);
    xfer(1, 64'h1122_3344_5566_7788, 4, 2);

    // Back-to-back: second transfer accepted on the last beat of the first
    model_push(0, 64'h0000_0000_BBCC_DDEE, 2);
    model_push(0, 64'h0000_0000_1357_2468, 2);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 64'h0000_0000_BBCC_DDEE; in_count[0] = 3'd2;
    out_ready[0] = 1'b1;
    #1 check("b2b_accept_a", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    check("b2b_a0", 64'(obs_beat(0)), 64'(exp_q.pop_front()));
    check("b2b_busy_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 64'h0000_0000_1357_2468; in_count[0] = 3'd2;
    #1;
    check("b2b_a1", 64'(obs_beat(0)), 64'(exp_q.pop_front()));
    check("b2b_last_ready", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    check("b2b_no_gap", 64'(out_valid[0]), 64'd1);
    check("b2b_b0", 64'(obs_beat(0)), 64'(exp_q.pop_front()));
    @(negedge clk);
    #1 check("b2b_b1", 64'(obs_beat(0)), 64'(exp_q.pop_front()));
    @(negedge clk);
    #1 check("b2b_idle", 64'(out_valid[0]), 64'd0);

    // Edge counts
    xfer(0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
    xfer(0, 64'h0F1E_2D3C_4B5A_6978, 7, 0);
    xfer(0, 64'h9988_7766_5544_3322, 1, 0);
    xfer(1, 64'h9988_7766_5544_3322, 1, 0);

    // Randomized transfers on both instances
    for (int i = 0; i < 30; i++) begin
      xfer(0, {$urandom(), $urandom()}, $urandom_range(0, 7), 1);
      xfer(1, {$urandom(), $urandom()}, $urandom_range(0, 7), 1);
    end

    // Over-range flood to saturate the error counter
    for (int i = 0; i < 300; i++) xfer(0, {$urandom(), $urandom()}, $urandom_range(5, 7), 0);
    check("err_saturated", 64'(err_cnt[0]), 64'd255);

    // Asynchronous reset after beat 1 of 4
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 64'h1111_2222_3333_4444; in_count[0] = 3'd4;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    check("mid_rst_ready", 64'(in_ready[0]), 64'd1);
    check("mid_rst_idx", 64'(out_idx[0]), 64'd0);
    err_exp[0] = 0; err_exp[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 check("post_rst_quiet", 64'(out_valid[0]), 64'd0);
    end
    check("post_rst_err", 64'(err_cnt[0]), 64'd0);
    xfer(0, 64'h0102_0304_0506_0708, 4, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
